// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receiver.
//   state_t     : receiver FSM state encoding (also exported on the debug port)
//   OVERSAMPLE  : oversample ticks per bit
//   MID_START   : sample index used to confirm the start bit
//   calc_div    : clocks per oversample tick, rounded to nearest
// Optional feature macro: UART_RX_PARITY_EN (8E1 framing; see uart_rx.sv)
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_START  = 7;

    // Round CLK_HZ/(BAUD*OVERSAMPLE) to nearest. A result below 1 means the
    // clock is too slow for the baud rate; it is clamped to 1 so the
    // prescaler stays well formed.
    function automatic int calc_div(input int clk_hz, input int baud);
        int d;
        d = (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Core-side bus of the UART receiver.
//   DATA_O      : received byte
//   VALID_O     : DATA_O holds an unconsumed byte
//   READY_I     : consumer accepts DATA_O when VALID_O && READY_I on a rising edge
//   FRAME_ERR_O : one-cycle pulse, bad stop (or parity) bit
//   OVERRUN_O   : one-cycle pulse, byte dropped because the holding register was full
//   STATE_O     : receiver FSM state, debug visibility only
// Handshake: a transfer happens on every rising edge where VALID_O && READY_I.
// VALID_O never drops without a transfer, and DATA_O does not change while
// VALID_O is high and READY_I is low.
// master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_if;
    import uart_rx_pkg::*;

    logic [7:0] DATA_O;
    logic       VALID_O;
    logic       READY_I;
    logic       FRAME_ERR_O;
    logic       OVERRUN_O;
    state_t     STATE_O;

    modport master (
        output DATA_O, VALID_O, FRAME_ERR_O, OVERRUN_O, STATE_O,
        input  READY_I
    );

    modport slave (
        input  DATA_O, VALID_O, FRAME_ERR_O, OVERRUN_O, STATE_O,
        output READY_I
    );

endinterface

// File: rtl/uart_rx_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running prescaler producing one-cycle oversample ticks.
//   clk_i     : clock
//   rst_i     : asynchronous active-high reset
//   restart_i : force the count back to 0 (aligns tick phase to an event)
//   tick_o    : high for one cycle every DIV clocks
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A restart cycle never produces a tick, so the first tick after an edge
    // is a full DIV clocks later.
    assign tick_o = (cnt_q == LAST) && !restart_i;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with 16x oversampling, 2-flop input synchroniser,
// start-bit glitch rejection, framing and overrun detection.
//   CLK_I : system clock, rising edge
//   RST_I : asynchronous active-high reset
//   RX_I  : serial line, asynchronous, idle high
//   bus   : uart_rx_if.master (DATA_O, VALID_O, READY_I, FRAME_ERR_O,
//           OVERRUN_O, STATE_O)
// Optional feature macro: UART_RX_PARITY_EN -> 8E1 framing with a PARITY
// state after the data bits; a parity mismatch pulses FRAME_ERR_O and the
// byte is discarded.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic      CLK_I,
    input  logic      RST_I,
    input  logic      RX_I,
    uart_rx_if.master bus
);

    localparam int         DIV       = calc_div(CLK_HZ, BAUD);
    localparam logic [3:0] SCNT_MID  = 4'(MID_START);
    localparam logic [3:0] SCNT_LAST = 4'(OVERSAMPLE - 1);

    // Synchroniser and edge detect
    logic [1:0] sync_q;
    logic       rx_s;
    logic       rx_prev_q;

    // Receive FSM
    state_t     state_q, state_d;
    logic [3:0] scnt_q, scnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       restart;
    logic       tick;
    logic       fsm_deliver;
    logic       fsm_frame_err;
`ifdef UART_RX_PARITY_EN
    logic       discard_q, discard_d;
`endif

    // Holding register / outputs
    logic       deliver_q;
    logic       frame_err_q;
    logic       overrun_q, overrun_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;

    assign rx_s = sync_q[1];

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk_i     (CLK_I),
        .rst_i     (RST_I),
        .restart_i (restart),
        .tick_o    (tick)
    );

    // ---------------------------------------------------------------------
    // FSM next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        scnt_d        = scnt_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        restart       = 1'b0;
        fsm_deliver   = 1'b0;
        fsm_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        discard_d     = discard_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    // Re-phase the prescaler so oversample ticks line up with
                    // the start edge.
                    state_d = ST_START;
                    scnt_d  = '0;
                    restart = 1'b1;
`ifdef UART_RX_PARITY_EN
                    discard_d = 1'b0;
`endif
                end
            end

            ST_START: begin
                if (tick) begin
                    if (scnt_q == SCNT_MID) begin
                        scnt_d  = '0;
                        bit_d   = '0;
                        // Line back high at mid start bit: a glitch, not a frame.
                        state_d = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        scnt_d = scnt_q + 4'd1;
                    end
                end
            end

            ST_DATA: begin
                if (tick) begin
                    if (scnt_q == SCNT_LAST) begin
                        scnt_d  = '0;
                        shift_d = {rx_s, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        scnt_d = scnt_q + 4'd1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (scnt_q == SCNT_LAST) begin
                        scnt_d  = '0;
                        state_d = ST_STOP;
                        // Even parity: data bits plus parity bit XOR to 0.
                        if (^{shift_q, rx_s}) begin
                            fsm_frame_err = 1'b1;
                            discard_d     = 1'b1;
                        end
                    end else begin
                        scnt_d = scnt_q + 4'd1;
                    end
                end
            end
`endif

            ST_STOP: begin
                if (tick) begin
                    if (scnt_q == SCNT_LAST) begin
                        scnt_d = '0;
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            fsm_deliver = !discard_q;
`else
                            fsm_deliver = 1'b1;
`endif
                            state_d = ST_IDLE;
                        end else begin
                            fsm_frame_err = 1'b1;
                            state_d       = ST_BREAK;
                        end
                    end else begin
                        scnt_d = scnt_q + 4'd1;
                    end
                end
            end

            ST_BREAK: begin
                // Stay here while the line is held low so a break does not
                // look like a stream of start bits.
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Holding register: load on the cycle after the stop sample
    // ---------------------------------------------------------------------
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (valid_q && bus.READY_I) begin
            valid_d = 1'b0;
        end
        if (deliver_q) begin
            // Accepting the old byte in this same cycle frees the register.
            if (!valid_q || bus.READY_I) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            sync_q      <= 2'b11;
            rx_prev_q   <= 1'b1;
            state_q     <= ST_IDLE;
            scnt_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            deliver_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            discard_q   <= 1'b0;
`endif
        end else begin
            sync_q      <= {sync_q[0], RX_I};
            rx_prev_q   <= rx_s;
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            deliver_q   <= fsm_deliver;
            frame_err_q <= fsm_frame_err;
            overrun_q   <= overrun_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
`ifdef UART_RX_PARITY_EN
            discard_q   <= discard_d;
`endif
        end
    end

    assign bus.DATA_O      = data_q;
    assign bus.VALID_O     = valid_q;
    assign bus.FRAME_ERR_O = frame_err_q;
    assign bus.OVERRUN_O   = overrun_q;
    assign bus.STATE_O     = state_q;

endmodule
